// File: rtl/display_commit_ctrl_pkg.sv
// Shared Tetris display types, VGA timing constants and commit FSM state.
// Optional blink feature in the top is enabled by DISPLAY_COMMIT_BLINK_EN.
package display_commit_ctrl_pkg;

  localparam int FIELD_HORIZONTAL       = 10;
  localparam int FIELD_VERTICAL_DISPLAY = 20;

  typedef enum logic [2:0] {
    TETROMINO_I,
    TETROMINO_O,
    TETROMINO_T,
    TETROMINO_S,
    TETROMINO_Z,
    TETROMINO_J,
    TETROMINO_L,
    TETROMINO_EMPTY
  } tetromino_t;

  typedef tetromino_t
    [FIELD_VERTICAL_DISPLAY-1:0]
    [FIELD_HORIZONTAL-1:0] field_t;

  localparam int H_ACTIVE = 1280;
  localparam int H_TOTAL  = 1680;
  localparam int V_ACTIVE_LINES = 800;
  localparam int V_TOTAL  = 831;

  typedef enum logic {
    COMMIT_IDLE,
    COMMIT_PENDING
  } commit_state_e;

  function automatic field_t empty_field();
    field_t f;
    for (int r = 0; r < FIELD_VERTICAL_DISPLAY; r++)
      for (int c = 0; c < FIELD_HORIZONTAL; c++)
        f[r][c] = TETROMINO_EMPTY;
    return f;
  endfunction

endpackage

// File: rtl/display_commit_ctrl_vblank_edge_detect.sv
// Single-cycle vblank_start pulse on the first line equal to V_ACTIVE.
// Part of display_commit_ctrl (see top for DISPLAY_COMMIT_BLINK_EN).
module vblank_edge_detect
  import display_commit_ctrl_pkg::*;
#(
  parameter int V_ACTIVE = V_ACTIVE_LINES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] curr_y,
  output logic       vblank_start
);

  logic at_v;
  logic prev_at_v_q;
  logic prev_at_v_d;

  always_comb begin
    at_v        = (curr_y == 10'(V_ACTIVE));
    prev_at_v_d = at_v;
    vblank_start = at_v && !prev_at_v_q;
  end

  always_ff @(posedge clk) begin
    if (rst) prev_at_v_q <= 1'b0;
    else     prev_at_v_q <= prev_at_v_d;
  end

endmodule

// File: rtl/display_commit_ctrl.sv
// Frame-synchronous snapshot commit into the renderer registers at vblank.
// Define DISPLAY_COMMIT_BLINK_EN to blink the grid while game over.
module display_commit_ctrl
  import display_commit_ctrl_pkg::*;
#(
  parameter int V_ACTIVE     = V_ACTIVE_LINES,
  parameter int FRAME_CNT_W  = 16
`ifdef DISPLAY_COMMIT_BLINK_EN
  ,
  parameter int BLINK_FRAMES = 30
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [9:0]             curr_y,
  input  logic                   upd_valid,
  output logic                   upd_ready,
  input  field_t                 upd_field,
  input  logic [31:0]            upd_score,
  input  logic                   upd_game_over,
  output field_t                 display,
  output logic [31:0]            score,
  output logic                   game_over,
  output logic                   commit,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   blank
);

  logic vblank_start;

  vblank_edge_detect #(
    .V_ACTIVE(V_ACTIVE)
  ) u_vbl (
    .clk         (clk),
    .rst         (rst),
    .curr_y      (curr_y),
    .vblank_start(vblank_start)
  );

  commit_state_e state_q, state_d;
  field_t        buf_field_q, buf_field_d;
  logic [31:0]   buf_score_q, buf_score_d;
  logic          buf_go_q, buf_go_d;
  field_t        disp_q, disp_d;
  logic [31:0]   score_q, score_d;
  logic          go_q, go_d;
  logic          commit_q, commit_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    state_d     = state_q;
    buf_field_d = buf_field_q;
    buf_score_d = buf_score_q;
    buf_go_d    = buf_go_q;
    disp_d      = disp_q;
    score_d     = score_q;
    go_d        = go_q;
    commit_d    = 1'b0;
    frame_cnt_d = frame_cnt_q +
      {{(FRAME_CNT_W-1){1'b0}}, vblank_start};
    upd_ready   = (state_q == COMMIT_IDLE);
    unique case (1'b1)
      (state_q == COMMIT_IDLE): begin
        if (upd_valid) begin
          buf_field_d = upd_field;
          buf_score_d = upd_score;
          buf_go_d    = upd_game_over;
          state_d     = COMMIT_PENDING;
        end
      end
      (state_q == COMMIT_PENDING): begin
        if (vblank_start) begin
          disp_d   = buf_field_q;
          score_d  = buf_score_q;
          go_d     = buf_go_q;
          commit_d = 1'b1;
          state_d  = COMMIT_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= COMMIT_IDLE;
      buf_field_q <= empty_field();
      buf_score_q <= '0;
      buf_go_q    <= 1'b0;
      disp_q      <= empty_field();
      score_q     <= '0;
      go_q        <= 1'b0;
      commit_q    <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      buf_field_q <= buf_field_d;
      buf_score_q <= buf_score_d;
      buf_go_q    <= buf_go_d;
      disp_q      <= disp_d;
      score_q     <= score_d;
      go_q        <= go_d;
      commit_q    <= commit_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

`ifdef DISPLAY_COMMIT_BLINK_EN
  localparam int BW =
    (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic          blank_q, blank_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;

  // counting uses the already-committed flag, so the commit frame itself is not counted
  always_comb begin
    blank_d     = blank_q;
    blink_cnt_d = blink_cnt_q;
    if (vblank_start && go_q) begin
      if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
        blank_d     = ~blank_q;
        blink_cnt_d = '0;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
    if (commit_d && !buf_go_q) begin
      blank_d     = 1'b0;
      blink_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blank_q     <= 1'b0;
      blink_cnt_q <= '0;
    end else begin
      blank_q     <= blank_d;
      blink_cnt_q <= blink_cnt_d;
    end
  end

  assign blank = blank_q;
`else
  assign blank = 1'b0;
`endif

  assign display   = disp_q;
  assign score     = score_q;
  assign game_over = go_q;
  assign commit    = commit_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_display_commit_ctrl.sv
// Randomized bench for display_commit_ctrl against a snapshot-level model.
// Honors DISPLAY_COMMIT_BLINK_EN (uses BLINK_FRAMES=2 when defined).
module tb_display_commit_ctrl;
  import display_commit_ctrl_pkg::*;

  localparam int VA = 800;
`ifdef DISPLAY_COMMIT_BLINK_EN
  localparam int BF = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  curr_y;
  logic        upd_valid;
  logic        upd_ready;
  field_t      upd_field;
  logic [31:0] upd_score;
  logic        upd_game_over;
  field_t      display;
  logic [31:0] score;
  logic        game_over;
  logic        commit;
  logic [15:0] frame_cnt;
  logic        blank;

  logic        s_ready;
  field_t      s_display;
  logic [31:0] s_score;
  logic        s_go;
  logic        s_commit;
  logic [2:0]  s_frame_cnt;
  logic        s_blank;

  always #5 clk = ~clk;

  display_commit_ctrl #(
    .V_ACTIVE(VA),
    .FRAME_CNT_W(16)
`ifdef DISPLAY_COMMIT_BLINK_EN
    , .BLINK_FRAMES(BF)
`endif
  ) dut (
    .clk(clk), .rst(rst), .curr_y(curr_y),
    .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_field(upd_field), .upd_score(upd_score),
    .upd_game_over(upd_game_over),
    .display(display), .score(score),
    .game_over(game_over), .commit(commit),
    .frame_cnt(frame_cnt), .blank(blank)
  );

  // narrow counter copy so wrap-around is reached quickly
  display_commit_ctrl #(
    .V_ACTIVE(VA),
    .FRAME_CNT_W(3)
`ifdef DISPLAY_COMMIT_BLINK_EN
    , .BLINK_FRAMES(BF)
`endif
  ) dut_w3 (
    .clk(clk), .rst(rst), .curr_y(curr_y),
    .upd_valid(upd_valid), .upd_ready(s_ready),
    .upd_field(upd_field), .upd_score(upd_score),
    .upd_game_over(upd_game_over),
    .display(s_display), .score(s_score),
    .game_over(s_go), .commit(s_commit),
    .frame_cnt(s_frame_cnt), .blank(s_blank)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag,
                     input logic [639:0] act,
                     input logic [639:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    else
      n_pass++;
  endtask

  // reference model: one optional pending snapshot plus committed view
  logic        m_pend;
  field_t      m_bf;
  logic [31:0] m_bs;
  logic        m_bg;
  field_t      m_disp;
  logic [31:0] m_score;
  logic        m_go;
  logic        m_commit;
  int          m_frames;
  int          m_last_y;
  logic        m_blank;
  int          m_bcnt;

  function automatic field_t rand_field();
    field_t f;
    for (int r = 0; r < FIELD_VERTICAL_DISPLAY; r++)
      for (int c = 0; c < FIELD_HORIZONTAL; c++)
        f[r][c] = tetromino_t'($urandom_range(0, 7));
    return f;
  endfunction

  task automatic step(input logic r, input int y,
                      input logic v, input field_t f,
                      input logic [31:0] s, input logic g);
    logic vs;
    rst = r; curr_y = 10'(y); upd_valid = v;
    upd_field = f; upd_score = s; upd_game_over = g;
    #1;
    if (!r) chk("upd_ready", 640'(upd_ready), 640'(!m_pend));
    if (r) begin
      m_pend = 0; m_disp = empty_field(); m_score = 0;
      m_go = 0; m_commit = 0; m_frames = 0; m_last_y = -1;
      m_blank = 0; m_bcnt = 0;
    end else begin
      vs = (y == VA) && (m_last_y != VA);
      m_commit = 0;
      if (vs) begin
        m_frames++;
`ifdef DISPLAY_COMMIT_BLINK_EN
        if (m_go) begin
          m_bcnt++;
          if (m_bcnt == BF) begin
            m_bcnt = 0;
            m_blank = !m_blank;
          end
        end
`endif
      end
      if (m_pend && vs) begin
        m_disp = m_bf; m_score = m_bs; m_go = m_bg;
        m_commit = 1; m_pend = 0;
        if (!m_bg) begin m_blank = 0; m_bcnt = 0; end
      end else if (v && !m_pend) begin
        m_bf = f; m_bs = s; m_bg = g; m_pend = 1;
      end
      m_last_y = y;
    end
    @(posedge clk); #1;
    chk("commit", 640'(commit), 640'(m_commit));
    chk("score", 640'(score), 640'(m_score));
    chk("game_over", 640'(game_over), 640'(m_go));
    chk("display", 640'(display), 640'(m_disp));
    chk("frame_cnt", 640'(frame_cnt), 640'(16'(m_frames)));
    chk("frame_cnt_w3", 640'(s_frame_cnt),
        640'(m_frames % 8));
    chk("blank", 640'(blank), 640'(m_blank));
  endtask

  field_t fa, fb;
  field_t cur_f;
  logic [31:0] cur_s;
  logic cur_g, cur_v;

  initial begin
    fa = rand_field();
    fb = rand_field();
    step(1, 0, 0, fa, 0, 0);
    step(1, 0, 0, fa, 0, 0);
    chk("rst_ready", 640'(upd_ready), 640'(1));
    chk("rst_display", 640'(display), 640'(empty_field()));

    for (int i = 0; i < 3; i++) begin
      step(0, 100, 0, fa, 0, 0);
      step(0, 800, 0, fa, 0, 0);
      step(0, 801, 0, fa, 0, 0);
    end
    chk("three_frames", 640'(frame_cnt), 640'(3));
    chk("idle_score", 640'(score), 640'(0));

    step(0, 100, 1, fa, 42, 0);
    chk("ready_drop", 640'(upd_ready), 640'(0));
    step(0, 500, 0, fa, 0, 0);
    chk("score_wait", 640'(score), 640'(0));
    step(0, 800, 0, fa, 0, 0);
    chk("score42", 640'(score), 640'(42));
    chk("commit42", 640'(commit), 640'(1));
    step(0, 801, 0, fa, 0, 0);
    chk("commit_once", 640'(commit), 640'(0));
    chk("ready_back", 640'(upd_ready), 640'(1));

    step(0, 100, 1, fa, 11, 0);
    step(0, 101, 1, fb, 22, 0);
    step(0, 102, 1, fb, 22, 0);
    step(0, 800, 1, fb, 22, 0);
    chk("a_commit", 640'(score), 640'(11));
    step(0, 801, 1, fb, 22, 0);
    step(0, 100, 0, fa, 0, 0);
    chk("b_held", 640'(score), 640'(11));
    step(0, 800, 0, fa, 0, 0);
    chk("b_commit", 640'(score), 640'(22));

    step(0, 799, 0, fa, 0, 0);
    step(0, 800, 1, fa, 33, 1);
    chk("vs_accept_nocommit", 640'(commit), 640'(0));
    step(0, 801, 0, fa, 0, 0);
    step(0, 800, 0, fa, 0, 0);
    chk("vs_accept_later", 640'(score), 640'(33));

    step(0, 100, 1, fb, 77, 1);
    step(1, 100, 0, fa, 0, 0);
    step(0, 100, 0, fa, 0, 0);
    chk("rst_pend_ready", 640'(upd_ready), 640'(1));
    step(0, 800, 0, fa, 0, 0);
    chk("rst_pend_lost", 640'(score), 640'(0));
    chk("rst_pend_disp", 640'(display), 640'(empty_field()));

    cur_v = 0; cur_f = fa; cur_s = 0; cur_g = 0;
    for (int i = 0; i < 3000; i++) begin
      int y;
      logic r;
      if (!cur_v && $urandom_range(0, 2) == 0) begin
        cur_v = 1; cur_f = rand_field();
        cur_s = $urandom(); cur_g = $urandom_range(0, 1) == 1;
      end
      y = ($urandom_range(0, 3) == 0) ? VA :
          int'($urandom_range(0, 1023));
      r = ($urandom_range(0, 499) == 0);
      if (cur_v && !m_pend && !r) begin
        step(r, y, cur_v, cur_f, cur_s, cur_g);
        cur_v = 0;
      end else begin
        step(r, y, cur_v, cur_f, cur_s, cur_g);
        if (r) cur_v = 0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
